cell_vector_sequencer: RTL and testbench

CELL_VECTOR_SEQUENCER -- requirements
Module: cell_vector_sequencer

---
 rtl/cell_vector_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cell_vector_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cell_vector_sequencer.sv
// cell_vector_sequencer
// Drives all 16 input combinations {A,B,C1,C2} into a 4-input cell and holds
// each one for SETTLE cycles. It then samples ZN for one cycle and compares it
// with a golden truth table latched at start. Mismatches are counted, and the
// index of the first mismatch is recorded.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   start          : one-cycle run request, honoured only when idle
//   golden[15:0]   : expected ZN, bit i for vector i (latched at start)
//   vec[3:0]       : cell inputs, vec[3]=A, vec[2]=B, vec[1]=C1, vec[0]=C2
//   dut_zn         : cell output ZN
//   busy           : run in progress
//   done           : one-cycle pulse at run end
//   pass           : last completed run had zero mismatches
//   result[15:0]   : captured ZN truth table
//   fail_count[4:0]: mismatch count of the run (0..16)
//   first_fail_idx : index of the first mismatch
//   fail_valid     : first_fail_idx is meaningful
module cell_vector_sequencer #(
    // Hold cycles per vector before sampling; legal range 1..15.
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] golden,
    output logic [3:0]  vec,
    input  logic        dut_zn,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail_idx,
    output logic        fail_valid
);

    localparam logic [3:0] LP_RELOAD    = 4'(SETTLE - 1);
    localparam logic [4:0] LP_MAX_FAILS = 5'd16;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSample,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;

    logic [15:0] r_golden;
    logic [3:0]  r_vec;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_result;
    logic [4:0]  r_fail_count;
    logic [3:0]  r_first_fail_idx;
    logic        r_fail_valid;

    logic        w_mismatch;
    logic [4:0]  w_fail_count_nxt;

    assign w_mismatch = dut_zn ^ r_golden[r_vec];

    // Saturating count; pass for the last vector must include its own sample.
    always_comb begin
        w_fail_count_nxt = r_fail_count;
        if (w_mismatch && (r_fail_count != LP_MAX_FAILS)) begin
            w_fail_count_nxt = r_fail_count + 5'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = StSample;
                end
            end
            StSample: begin
                if (r_vec == 4'd15) begin
                    w_state_nxt = StDone;
                end else begin
                    w_state_nxt = StWait;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_golden         <= 16'd0;
            r_vec            <= 4'd0;
            r_cnt            <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_result         <= 16'd0;
            r_fail_count     <= 5'd0;
            r_first_fail_idx <= 4'd0;
            r_fail_valid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_golden     <= golden;
                        r_vec        <= 4'd0;
                        r_cnt        <= LP_RELOAD;
                        r_busy       <= 1'b1;
                        r_result     <= 16'd0;
                        r_fail_count <= 5'd0;
                        r_fail_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StSample: begin
                    r_result[r_vec] <= dut_zn;
                    r_fail_count    <= w_fail_count_nxt;
                    if (w_mismatch && !r_fail_valid) begin
                        r_first_fail_idx <= r_vec;
                        r_fail_valid     <= 1'b1;
                    end
                    if (r_vec != 4'd15) begin
                        r_vec <= r_vec + 4'd1;
                        r_cnt <= LP_RELOAD;
                    end else begin
                        // Outputs for the DONE cycle are set on the entry edge.
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_fail_count_nxt == 5'd0);
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign vec            = r_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign result         = r_result;
    assign fail_count     = r_fail_count;
    assign first_fail_idx = r_first_fail_idx;
    assign fail_valid     = r_fail_valid;

endmodule

// File: tb/tb_cell_vector_sequencer.sv
// Directed bench for cell_vector_sequencer: two instances (SETTLE=2 and 1),
// each driving a behavioural AOI211 cell, ZN = !(A|B|(C1&C2)).
module tb_cell_vector_sequencer;

    logic        clk;
    logic        rst_n;

    logic        a_start, b_start;
    logic [15:0] a_golden, b_golden;
    logic [3:0]  a_vec, b_vec;
    logic        a_zn, b_zn;
    logic        a_busy, b_busy, a_done, b_done, a_pass, b_pass;
    logic [15:0] a_result, b_result;
    logic [4:0]  a_fcnt, b_fcnt;
    logic [3:0]  a_ffi, b_ffi;
    logic        a_fv, b_fv;

    int errs;
    int checks;

    assign a_zn = !(a_vec[3] | a_vec[2] | (a_vec[1] & a_vec[0]));
    assign b_zn = !(b_vec[3] | b_vec[2] | (b_vec[1] & b_vec[0]));

    cell_vector_sequencer #(.SETTLE(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .golden(a_golden), .vec(a_vec),
        .dut_zn(a_zn), .busy(a_busy), .done(a_done), .pass(a_pass), .result(a_result),
        .fail_count(a_fcnt), .first_fail_idx(a_ffi), .fail_valid(a_fv)
    );

    cell_vector_sequencer #(.SETTLE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .golden(b_golden), .vec(b_vec),
        .dut_zn(b_zn), .busy(b_busy), .done(b_done), .pass(b_pass), .result(b_result),
        .fail_count(b_fcnt), .first_fail_idx(b_ffi), .fail_valid(b_fv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run on instance inst (0: SETTLE=2, 1: SETTLE=1). With disturb set,
    // start is pulsed and golden inverted mid-run, and start is raised in DONE.
    task automatic do_run(input bit inst, input logic [15:0] g, input bit disturb,
                          output int done_edge, output int vec_err,
                          output int busy_err, output int pulses);
        int s1;
        int exp_vec;
        logic [3:0] v;
        logic b, d;
        s1 = inst ? 2 : 3;
        done_edge = -1;
        vec_err = 0;
        busy_err = 0;
        pulses = 0;
        @(negedge clk);
        if (inst) begin b_golden = g; b_start = 1'b1; end
        else begin a_golden = g; a_start = 1'b1; end
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            v = inst ? b_vec : a_vec;
            b = inst ? b_busy : a_busy;
            d = inst ? b_done : a_done;
            exp_vec = (n / s1 > 15) ? 15 : n / s1;
            if (v !== 4'(exp_vec)) vec_err++;
            if (b !== (n < 16 * s1)) busy_err++;
            if (d === 1'b1) begin
                pulses++;
                if (done_edge < 0) begin
                    done_edge = n;
                    if (disturb) begin
                        if (inst) b_start = 1'b1; else a_start = 1'b1;
                    end
                end
            end
            if (disturb && n == 10) begin
                if (inst) begin b_start = 1'b1; b_golden = ~g; end
                else begin a_start = 1'b1; a_golden = ~g; end
            end
            if (disturb && (n == 11 || n == done_edge + 1)) begin
                a_start = 1'b0;
                b_start = 1'b0;
            end
            if (done_edge >= 0 && n >= done_edge + 6) break;
        end
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    initial begin
        int de, ve, be, dp;
        errs = 0;
        checks = 0;
        rst_n = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        a_golden = 16'h0;
        b_golden = 16'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_a_outs", {a_vec, a_busy, a_done, a_pass, a_fcnt, a_ffi, a_fv}, 32'h0);
        chk("reset_a_result", {16'h0, a_result}, 32'h0);
        chk("reset_b_outs", {b_vec, b_busy, b_done, b_pass, b_fcnt, b_ffi, b_fv}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Golden matches the AOI211 truth table.
        do_run(1'b0, 16'h0007, 1'b0, de, ve, be, dp);
        chk("r1_done_edge", de, 48);
        chk("r1_done_pulses", dp, 1);
        chk("r1_vec_seq_err", ve, 0);
        chk("r1_busy_err", be, 0);
        chk("r1_result", a_result, 16'h0007);
        chk("r1_fail_count", a_fcnt, 0);
        chk("r1_pass", a_pass, 1);
        chk("r1_fail_valid", a_fv, 0);

        // Single mismatch at vector 0.
        do_run(1'b0, 16'h0006, 1'b0, de, ve, be, dp);
        chk("r2_done_edge", de, 48);
        chk("r2_fail_count", a_fcnt, 1);
        chk("r2_first_idx", a_ffi, 0);
        chk("r2_fail_valid", a_fv, 1);
        chk("r2_pass", a_pass, 0);
        chk("r2_result", a_result, 16'h0007);

        // Every vector mismatches.
        do_run(1'b0, 16'hFFF8, 1'b0, de, ve, be, dp);
        chk("r3_fail_count", a_fcnt, 16);
        chk("r3_first_idx", a_ffi, 0);
        chk("r3_fail_valid", a_fv, 1);
        chk("r3_pass", a_pass, 0);
        chk("r3_result", a_result, 16'h0007);

        // Mid-run start/golden change and start in DONE are ignored.
        do_run(1'b0, 16'h0007, 1'b1, de, ve, be, dp);
        chk("r4_done_edge", de, 48);
        chk("r4_done_pulses", dp, 1);
        chk("r4_vec_seq_err", ve, 0);
        chk("r4_busy_err", be, 0);
        chk("r4_result", a_result, 16'h0007);
        chk("r4_fail_count", a_fcnt, 0);
        chk("r4_pass", a_pass, 1);
        chk("r4_fail_valid", a_fv, 0);

        // Reset mid-run with vec=5 after mismatches have accumulated.
        @(negedge clk);
        a_golden = 16'hFFF8;
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("r5_vec_before_rst", a_vec, 5);
        chk("r5_fcnt_before_rst", a_fcnt, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("r5_outs_in_rst", {a_vec, a_busy, a_done, a_pass, a_fcnt, a_ffi, a_fv}, 32'h0);
        chk("r5_result_in_rst", {16'h0, a_result}, 32'h0);
        dp = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (a_done === 1'b1) dp++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (a_done === 1'b1 || a_busy === 1'b1) dp++;
        end
        chk("r5_no_done_after_rst", dp, 0);
        do_run(1'b0, 16'h0007, 1'b0, de, ve, be, dp);
        chk("r5_done_edge", de, 48);
        chk("r5_vec_seq_err", ve, 0);
        chk("r5_result", a_result, 16'h0007);
        chk("r5_pass", a_pass, 1);
        chk("r5_fail_count", a_fcnt, 0);

        // SETTLE=1 instance.
        do_run(1'b1, 16'h0007, 1'b0, de, ve, be, dp);
        chk("r6_done_edge", de, 32);
        chk("r6_done_pulses", dp, 1);
        chk("r6_vec_seq_err", ve, 0);
        chk("r6_busy_err", be, 0);
        chk("r6_result", b_result, 16'h0007);
        chk("r6_pass", b_pass, 1);
        chk("r6_fail_valid", b_fv, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
